div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 The module SHALL have port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The module SHALL have port `rst`, input, 1 bit: reset, synchronous, active-high.
REQ-003 The module SHALL have port `signed_div_i`, input, 1 bit: 1 = signed (two's complement) division, 0 = unsigned.
REQ-004 The module SHALL have port `opdata1_i`, input, 32 bits: dividend, taken from the execute-stage source operand 1.
REQ-005 The module SHALL have port `opdata2_i`, input, 32 bits: divisor, taken from the execute-stage source operand 2.
REQ-006 The module SHALL have port `start_i`, input, 1 bit: division request, held high by the execute stage until the result is consumed.
REQ-007 The module SHALL have port `annul_i`, input, 1 bit: cancels an in-progress division.
REQ-008 The module SHALL have port `result_o`, output, 64 bits: {remainder[63:32], quotient[31:0]}.
REQ-009 The module SHALL have port `ready_o`, output, 1 bit: result valid.

Function
REQ-010 The block SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-011 In FREE with `start_i`=1 and `annul_i`=0, the block SHALL sample all operands at that edge (E0).
REQ-012 On E0, a divisor of 0 SHALL move the FSM to BYZERO; any non-zero divisor SHALL move it to ON with iteration counter cnt=0.
REQ-013 Operand changes after E0 SHALL be ignored until the FSM returns to FREE.
REQ-014 Signed mode SHALL use operand magnitudes: a negative dividend or divisor SHALL be two's-complement negated at E0; unsigned mode SHALL use operands as-is.
REQ-015 ON SHALL perform restoring shift-subtract, one quotient bit per edge, MSB first, for 32 edges (E1..E32) with cnt going 0 to 32.
REQ-016 The working remainder SHALL be 33 bits wide so the subtract borrow is explicit.
REQ-017 On the edge where the FSM is in ON and cnt=32 (E33), the block SHALL apply the sign fix-up, load `result_o`, set `ready_o`=1, and enter END.
REQ-018 Sign fix-up in signed mode: the quotient SHALL be negated iff the dividend and divisor signs differ.
REQ-019 Sign fix-up in signed mode: the remainder SHALL be negated iff the dividend is negative.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (natural wrap, no trap).
REQ-021 BYZERO SHALL move to END on the next edge (E1) with `result_o`=0 and `ready_o`=1.
REQ-022 END SHALL hold `result_o` and `ready_o`=1 while `start_i`=1.
REQ-023 In END, the first edge with `start_i`=0 SHALL return the FSM to FREE with `ready_o`=0 and `result_o`=0.
REQ-024 Latency from E0 to `ready_o` high SHALL be 33 edges for a non-zero divisor and 1 edge for a zero divisor.
REQ-025 `annul_i`=1 in ON or BYZERO SHALL return the FSM to FREE at that edge, with `ready_o`=0, `result_o`=0, and the iteration discarded.
REQ-026 `annul_i`=1 in FREE SHALL block a start, even if `start_i`=1 in the same cycle.
REQ-027 `start_i` deasserting during ON SHALL NOT abort the division; only `annul_i` aborts it.
REQ-028 A new start in END SHALL NOT be accepted; the FSM SHALL pass through FREE first (minimum one idle cycle between divisions).
REQ-029 `ready_o` and `result_o` SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-030 When `rst`=1 at a rising edge, the block SHALL set FSM=FREE, cnt=0, `ready_o`=0, `result_o`=64'h0, and clear all working registers, regardless of state.
REQ-031 Reset SHALL take priority over `annul_i` and `start_i`.
REQ-032 Reset asserted mid-division SHALL discard the operation, and `ready_o` SHALL never pulse for it.
REQ-033 While `rst`=1, `start_i` SHALL be ignored.

Verification
REQ-034 Unsigned: `signed_div_i`=0, opdata1=100, opdata2=7, `start_i` held -> `ready_o`=1 exactly 33 edges after E0, `result_o`={32'd2, 32'd14}.
REQ-035 Signed mixed sign: `signed_div_i`=1, opdata1=-7 (0xFFFFFFF9), opdata2=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
REQ-036 Divide by zero: opdata1=0x1234, opdata2=0 -> `ready_o`=1 after 1 edge, `result_o`=0; drop `start_i` -> `ready_o`=0 on the next edge.
REQ-037 Annul: start 100/7, assert `annul_i` at edge E10 -> FSM in FREE, `ready_o` stays 0 for 40 further cycles with `start_i`=0.
REQ-038 Reset mid-operation: start 0xFFFFFFFF/3 unsigned, assert `rst` at E20 -> all outputs 0; restart after release -> result {0, 0x55555555} 33 edges after the new E0.
REQ-039 Signed overflow and back-to-back: 0x80000000 / 0xFFFFFFFF signed -> {0, 0x80000000}; then immediate re-request after `start_i` low for exactly one cycle -> second result correct, with no operand leakage from the first division.

Source files
------------

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider, signed or unsigned, with annul.
// Ports: clk, rst, signed_div_i, opdata1_i, opdata2_i, start_i, annul_i -> result_o {rem,quo}, ready_o.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE,
    BYZERO,
    ON,
    END
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;

  logic        take;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] trial;
  logic [32:0] diff;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign take  = start_i && !annul_i;
  assign a_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign b_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // 33-bit trial remainder: bit 32 of the difference is the borrow,
  // set exactly when the shifted remainder is below the divisor.
  assign trial = {rem, quo[31]};
  assign diff  = trial - {1'b0, dvs};

  assign q_fix = neg_q ? (~quo + 32'd1) : quo;
  assign r_fix = neg_r ? (~rem + 32'd1) : rem;

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FREE: begin
        if (take) state_nxt = (opdata2_i == 32'd0) ? BYZERO : ON;
      end
      BYZERO: begin
        state_nxt = annul_i ? FREE : END;
      end
      ON: begin
        if (annul_i)             state_nxt = FREE;
        else if (cnt == 6'd32)   state_nxt = END;
      end
      END: begin
        if (!start_i) state_nxt = FREE;
      end
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 6'd0;
      quo      <= 32'd0;
      rem      <= 32'd0;
      dvs      <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        FREE: begin
          if (take) begin
            cnt   <= 6'd0;
            quo   <= a_abs;
            rem   <= 32'd0;
            dvs   <= b_abs;
            neg_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_r <= signed_div_i && opdata1_i[31];
          end
          result_o <= 64'd0;
          ready_o  <= 1'b0;
        end
        BYZERO: begin
          result_o <= 64'd0;
          ready_o  <= !annul_i;
        end
        ON: begin
          if (annul_i) begin
            cnt      <= 6'd0;
            quo      <= 32'd0;
            rem      <= 32'd0;
            dvs      <= 32'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else if (cnt != 6'd32) begin
            rem <= diff[32] ? trial[31:0] : diff[31:0];
            quo <= {quo[30:0], ~diff[32]};
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
          end
        end
        END: begin
          if (!start_i) begin
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          result_o <= 64'd0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for the restoring divider.
// Drives and samples 1 time unit after each rising edge.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_div(input string tag, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [63:0] exp,
                         input bit hold);
    int n;
    signed_div = sgn;
    op1   = a;
    op2   = b;
    start = 1'b1;
    step();
    n = 0;
    op1 = $urandom;
    op2 = $urandom;
    signed_div = ~sgn;
    if (!hold) start = 1'b0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, result, exp);
    if (hold) begin
      step();
      chk({tag, "_hold_rdy"}, 64'(ready), 64'd1);
      chk({tag, "_hold_res"}, result, exp);
    end
    start = 1'b0;
    step();
    chk({tag, "_drop_rdy"}, 64'(ready), 64'd0);
    chk({tag, "_drop_res"}, result, 64'd0);
  endtask

  initial begin
    int hits;
    rst = 1'b1;
    signed_div = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    start = 1'b0;
    annul = 1'b0;
    step();
    step();
    chk("rst_rdy", 64'(ready), 64'd0);
    chk("rst_res", result, 64'd0);
    rst = 1'b0;
    step();

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b1);
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1);
    run_div("dz", 1'b0, 32'h1234, 32'd0, 1, 64'd0, 1'b1);
    run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 33, {32'd0, 32'hFFFFFFFF}, 1'b1);
    run_div("u5_10", 1'b0, 32'd5, 32'd10, 33, {32'd5, 32'd0}, 1'b1);
    run_div("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 33, {32'hFFFFFFFE, 32'd14}, 1'b1);
    run_div("nohold", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b0);

    // annul at E10
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    step();
    for (int i = 0; i < 9; i++) step();
    annul = 1'b1;
    start = 1'b0;
    step();
    chk("annul_rdy", 64'(ready), 64'd0);
    chk("annul_res", result, 64'd0);
    annul = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready) hits++;
    end
    chk("annul_quiet", 64'(hits), 64'd0);

    // annul in FREE blocks the start
    start = 1'b1;
    annul = 1'b1;
    step();
    start = 1'b0;
    annul = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready) hits++;
    end
    chk("annul_free", 64'(hits), 64'd0);

    // reset at E20, start held through reset
    op1 = 32'hFFFFFFFF;
    op2 = 32'd3;
    start = 1'b1;
    step();
    for (int i = 0; i < 19; i++) step();
    rst = 1'b1;
    step();
    chk("mid_rst_rdy", 64'(ready), 64'd0);
    chk("mid_rst_res", result, 64'd0);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready) hits++;
    end
    chk("rst_hold_quiet", 64'(hits), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    step();
    run_div("u_max_3", 1'b0, 32'hFFFFFFFF, 32'd3, 33, {32'd0, 32'h55555555}, 1'b1);

    // overflow case then back-to-back after one idle cycle
    run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, {32'd0, 32'h80000000}, 1'b1);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, {32'd1, 32'hFFFFFFFD}, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
